// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the fetch/data requesters, the memory port arbiter and the memory.
// The slave modport is the arbiter's view; master is the environment (requesters plus memory).
interface mem_port_arbiter_if #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
);
    // Fetch requester
    logic              if_req_i;
    logic [AWIDTH-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DWIDTH-1:0] if_rdata_o;

    // Data (load/store) requester
    logic              dm_req_i;
    logic              dm_we_i;
    logic [AWIDTH-1:0] dm_addr_i;
    logic [DWIDTH-1:0] dm_wdata_i;
    logic [1:0]        dm_size_i;
    logic              dm_gnt_o;
    logic              dm_rvalid_o;
    logic [DWIDTH-1:0] dm_rdata_o;

    // Memory side
    logic              mem_req_o;
    logic              mem_we_o;
    logic [AWIDTH-1:0] mem_addr_o;
    logic [DWIDTH-1:0] mem_wdata_o;
    logic [1:0]        mem_size_o;
    logic              mem_rvalid_i;
    logic [DWIDTH-1:0] mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_size_i,
        output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_size_o,
        input  mem_rvalid_i, mem_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_size_i,
        input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_size_o,
        output mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction in flight.
// Define MEM_ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_MAX back-to-back data grants.
module mem_port_arbiter #(
    parameter int unsigned AWIDTH     = 32,
    parameter int unsigned DWIDTH     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus,
    output logic                busy_o
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_starve_max_check
        $error("mem_port_arbiter: STARVE_MAX must be in 1..15");
    end

    typedef enum logic [0:0] {StIdle, StWait} state_e;
    typedef enum logic [1:0] {OwnNone, OwnFetch, OwnData} owner_e;

    state_e state_q, state_d;
    owner_e owner_q, owner_d;

    logic              fetch_priority;
    logic              grant_if;
    logic              grant_dm;
    logic              mem_req;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic [1:0]        mem_size;
    logic              if_rvalid;
    logic [DWIDTH-1:0] if_rdata;
    logic              dm_rvalid;
    logic [DWIDTH-1:0] dm_rdata;
    logic              busy;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [3:0] starve_q, starve_d;

    assign fetch_priority = (starve_q == 4'(STARVE_MAX));

    // Counts data grants that overtook a waiting fetch; any idle cycle without fetch resets it.
    always_comb begin
        starve_d = starve_q;
        if (!reset && state_q == StIdle) begin
            if (!bus.if_req_i || grant_if) begin
                starve_d = '0;
            end else if (grant_dm && starve_q != 4'hF) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign fetch_priority = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        grant_if  = 1'b0;
        grant_dm  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_size  = '0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        dm_rvalid = 1'b0;
        dm_rdata  = '0;
        busy      = 1'b0;

        // Reset forces every output low even while requests are present.
        if (!reset) begin
            unique case (state_q)
                StIdle: begin
                    grant_if = bus.if_req_i && (!bus.dm_req_i || fetch_priority);
                    grant_dm = bus.dm_req_i && !grant_if;
                    if (grant_if) begin
                        mem_req  = 1'b1;
                        mem_addr = bus.if_addr_i;
                        mem_size = 2'b10;
                        owner_d  = OwnFetch;
                        state_d  = StWait;
                    end else if (grant_dm) begin
                        mem_req   = 1'b1;
                        mem_we    = bus.dm_we_i;
                        mem_addr  = bus.dm_addr_i;
                        mem_wdata = bus.dm_wdata_i;
                        mem_size  = bus.dm_size_i;
                        owner_d   = OwnData;
                        state_d   = StWait;
                    end
                end
                StWait: begin
                    busy = 1'b1;
                    if (bus.mem_rvalid_i) begin
                        if (owner_q == OwnFetch) begin
                            if_rvalid = 1'b1;
                            if_rdata  = bus.mem_rdata_i;
                        end else if (owner_q == OwnData) begin
                            dm_rvalid = 1'b1;
                            dm_rdata  = bus.mem_rdata_i;
                        end
                        owner_d = OwnNone;
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                    owner_d = OwnNone;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            owner_q <= OwnNone;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    assign bus.if_gnt_o    = grant_if;
    assign bus.if_rvalid_o = if_rvalid;
    assign bus.if_rdata_o  = if_rdata;
    assign bus.dm_gnt_o    = grant_dm;
    assign bus.dm_rvalid_o = dm_rvalid;
    assign bus.dm_rdata_o  = dm_rdata;
    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_wdata_o = mem_wdata;
    assign bus.mem_size_o  = mem_size;
    assign busy_o          = busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by random traffic,
// all outputs compared every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned SMAX = 2;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit Guard = 1'b1;
`else
    localparam bit Guard = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic busy;

    mem_port_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    mem_port_arbiter #(
        .AWIDTH    (AW),
        .DWIDTH    (DW),
        .STARVE_MAX(SMAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: is a transaction outstanding, who owns it, was it a store,
    // and how many data grants have overtaken a waiting fetch.
    bit m_busy;
    int m_owner;  // 0 none, 1 fetch, 2 data
    bit m_store;
    int m_cnt;
    bit e_pf, e_pd;

    // Snapshot of DUT outputs from the last checked cycle
    logic          s_if_gnt, s_dm_gnt, s_if_rv, s_dm_rv, s_mreq, s_busy;
    logic [DW-1:0] s_if_rd, s_dm_rd;
    logic [AW-1:0] s_maddr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.if_req_i     = 1'b0;
        bus.if_addr_i    = '0;
        bus.dm_req_i     = 1'b0;
        bus.dm_we_i      = 1'b0;
        bus.dm_addr_i    = '0;
        bus.dm_wdata_i   = '0;
        bus.dm_size_i    = '0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
    endtask

    // Check one cycle at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        logic rv;
        @(negedge clk);
        e_pf = 1'b0;
        e_pd = 1'b0;
        if (!reset && !m_busy) begin
            e_pf = bus.if_req_i && (!bus.dm_req_i || (Guard && m_cnt == int'(SMAX)));
            e_pd = bus.dm_req_i && !e_pf;
        end
        s_if_gnt = bus.if_gnt_o;
        s_dm_gnt = bus.dm_gnt_o;
        s_if_rv  = bus.if_rvalid_o;
        s_dm_rv  = bus.dm_rvalid_o;
        s_if_rd  = bus.if_rdata_o;
        s_dm_rd  = bus.dm_rdata_o;
        s_mreq   = bus.mem_req_o;
        s_maddr  = bus.mem_addr_o;
        s_busy   = busy;

        chk("if_gnt", bus.if_gnt_o, e_pf);
        chk("dm_gnt", bus.dm_gnt_o, e_pd);
        chk("busy", busy, !reset && m_busy);
        if (reset || !m_busy) begin
            chk("mem_req", bus.mem_req_o, e_pf || e_pd);
            chk("mem_we", bus.mem_we_o, e_pd && bus.dm_we_i);
            chk("mem_addr", bus.mem_addr_o,
                e_pf ? bus.if_addr_i : (e_pd ? bus.dm_addr_i : 32'h0));
            chk("mem_wdata", bus.mem_wdata_o, e_pd ? bus.dm_wdata_i : 32'h0);
            chk("mem_size", bus.mem_size_o, e_pf ? 2'b10 : (e_pd ? bus.dm_size_i : 2'b00));
            chk("if_rvalid", bus.if_rvalid_o, 1'b0);
            chk("dm_rvalid", bus.dm_rvalid_o, 1'b0);
            chk("if_rdata", bus.if_rdata_o, 32'h0);
            chk("dm_rdata", bus.dm_rdata_o, 32'h0);
        end else begin
            rv = bus.mem_rvalid_i;
            chk("wait_mem_req", bus.mem_req_o, 1'b0);
            chk("if_rvalid", bus.if_rvalid_o, rv && m_owner == 1);
            chk("dm_rvalid", bus.dm_rvalid_o, rv && m_owner == 2);
            chk("if_rdata", bus.if_rdata_o, (rv && m_owner == 1) ? bus.mem_rdata_i : 32'h0);
            if (!(m_owner == 2 && m_store))
                chk("dm_rdata", bus.dm_rdata_o, (rv && m_owner == 2) ? bus.mem_rdata_i : 32'h0);
        end

        @(posedge clk);
        if (reset) begin
            m_busy  = 1'b0;
            m_owner = 0;
            m_cnt   = 0;
        end else if (!m_busy) begin
            if (Guard) begin
                if (!bus.if_req_i || e_pf) m_cnt = 0;
                else if (e_pd) m_cnt++;
            end
            if (e_pf || e_pd) begin
                m_busy  = 1'b1;
                m_owner = e_pf ? 1 : 2;
                m_store = e_pd && bus.dm_we_i;
            end
        end else if (bus.mem_rvalid_i) begin
            m_busy  = 1'b0;
            m_owner = 0;
        end
        #1;
    endtask

    initial begin
        string exp_pat;
        byte   got;
        m_busy  = 1'b0;
        m_owner = 0;
        m_store = 1'b0;
        m_cnt   = 0;
        reset   = 1'b1;
        idle_inputs();
        cycle();
        chk("reset_busy", s_busy, 1'b0);
        cycle();
        reset = 1'b0;
        cycle();

        // Single load, memory answers two cycles after issue
        bus.dm_req_i  = 1'b1;
        bus.dm_we_i   = 1'b0;
        bus.dm_addr_i = 32'h100;
        bus.dm_size_i = 2'b10;
        cycle();
        chk("load_gnt", s_dm_gnt, 1'b1);
        chk("load_addr", s_maddr, 32'h100);
        bus.dm_req_i = 1'b0;
        cycle();
        chk("load_busy1", s_busy, 1'b1);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hDEADBEEF;
        cycle();
        chk("load_rvalid", s_dm_rv, 1'b1);
        chk("load_rdata", s_dm_rd, 32'hDEADBEEF);
        chk("load_busy2", s_busy, 1'b1);
        idle_inputs();
        cycle();
        chk("load_done_busy", s_busy, 1'b0);

        // Fetch and store together: store first, fetch right after the acknowledge
        bus.if_req_i   = 1'b1;
        bus.if_addr_i  = 32'h0;
        bus.dm_req_i   = 1'b1;
        bus.dm_we_i    = 1'b1;
        bus.dm_addr_i  = 32'h200;
        bus.dm_wdata_i = 32'h5A5A0001;
        bus.dm_size_i  = 2'b10;
        cycle();
        chk("both_dm_first", s_dm_gnt, 1'b1);
        chk("both_if_held", s_if_gnt, 1'b0);
        bus.dm_req_i = 1'b0;
        cycle();
        chk("both_if_wait", s_if_gnt, 1'b0);
        bus.mem_rvalid_i = 1'b1;
        cycle();
        chk("store_ack", s_dm_rv, 1'b1);
        chk("store_ack_if", s_if_rv, 1'b0);
        chk("both_if_ack", s_if_gnt, 1'b0);
        bus.mem_rvalid_i = 1'b0;
        cycle();
        chk("both_if_gnt", s_if_gnt, 1'b1);
        bus.if_req_i     = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h0000CAFE;
        cycle();
        chk("fetch_rv", s_if_rv, 1'b1);
        chk("fetch_rd", s_if_rd, 32'h0000CAFE);
        chk("fetch_dm_rv", s_dm_rv, 1'b0);

        // Spurious response in IDLE
        idle_inputs();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h1234;
        cycle();
        chk("spur_if_rv", s_if_rv, 1'b0);
        chk("spur_dm_rv", s_dm_rv, 1'b0);
        idle_inputs();
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h10;
        cycle();
        chk("spur_then_gnt", s_if_gnt, 1'b1);
        bus.if_req_i     = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        cycle();
        idle_inputs();

        // Reset while WAIT: transaction dropped, outputs zero even with a request present
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h40;
        cycle();
        bus.if_req_i = 1'b0;
        cycle();
        chk("rst_pre_busy", s_busy, 1'b1);
        #2;
        reset        = 1'b1;
        bus.dm_req_i = 1'b1;
        cycle();
        chk("rst_busy", s_busy, 1'b0);
        chk("rst_mreq", s_mreq, 1'b0);
        chk("rst_dm_gnt", s_dm_gnt, 1'b0);
        bus.dm_req_i = 1'b0;
        cycle();
        reset            = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h77;
        cycle();
        chk("rst_late_rv", s_if_rv, 1'b0);
        bus.mem_rvalid_i = 1'b0;
        bus.if_req_i     = 1'b1;
        bus.if_addr_i    = 32'h80;
        cycle();
        chk("rst_next_gnt", s_if_gnt, 1'b1);
        bus.if_req_i     = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        cycle();
        idle_inputs();

        // Fetch request withdrawn while WAIT
        bus.dm_req_i  = 1'b1;
        bus.dm_addr_i = 32'h300;
        cycle();
        bus.dm_req_i  = 1'b0;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h44;
        cycle();
        bus.if_req_i     = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        cycle();
        bus.mem_rvalid_i = 1'b0;
        cycle();
        chk("withdraw_noreq0", s_mreq, 1'b0);
        cycle();
        chk("withdraw_noreq1", s_mreq, 1'b0);

        // Both requesters held continuously
        exp_pat       = Guard ? "DDFDDF" : "DDDDDD";
        bus.dm_req_i  = 1'b1;
        bus.dm_we_i   = 1'b0;
        bus.dm_addr_i = 32'h500;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h600;
        for (int k = 0; k < 6; k++) begin
            cycle();
            got = s_dm_gnt ? "D" : (s_if_gnt ? "F" : "?");
            chk($sformatf("starve_%0d", k), got, exp_pat[k]);
            bus.mem_rvalid_i = 1'b1;
            cycle();
            bus.mem_rvalid_i = 1'b0;
        end
        idle_inputs();
        cycle();

        // Random traffic obeying the requester rules
        for (int n = 0; n < 600; n++) begin
            bus.mem_rdata_i  = $urandom;
            bus.mem_rvalid_i = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            cycle();
            if (e_pf) bus.if_req_i = 1'b0;
            if (e_pd) bus.dm_req_i = 1'b0;
            if (bus.if_req_i && $urandom_range(0, 7) == 0) bus.if_req_i = 1'b0;
            if (bus.dm_req_i && $urandom_range(0, 7) == 0) bus.dm_req_i = 1'b0;
            if (!bus.if_req_i && $urandom_range(0, 2) == 0) begin
                bus.if_req_i  = 1'b1;
                bus.if_addr_i = $urandom;
            end
            if (!bus.dm_req_i && $urandom_range(0, 1) == 0) begin
                bus.dm_req_i   = 1'b1;
                bus.dm_we_i    = 1'($urandom_range(0, 1));
                bus.dm_addr_i  = $urandom;
                bus.dm_wdata_i = $urandom;
                bus.dm_size_i  = 2'($urandom_range(0, 3));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
